// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access sequencer. Turns a load/store request from the
// EX/MEM pipeline register into a held memory request, stalls the upstream
// pipeline until the memory acknowledges, and registers load data for MEM/WB.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a request that sees no
// mem_ack for TIMEOUT_CYCLES cycles (MemErrM pulses for the abort's DONE cycle).
//
// Parameters
//   TIMEOUT_CYCLES  REQ cycles without ack before abort (2..1023, timeout build)
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   MemWriteM       store request            MemtoRegM  load request
//   ALUOutM         byte address             WriteDataM store data
//   StallM          combinational upstream freeze
//   ReadDataM       registered load data     MemErrM    registered timeout pulse
//   mem_req/we/addr/wdata  registered memory request
//   mem_ack, mem_rdata     memory completion and read data
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        MemErrM
);

    localparam int unsigned DATA_W = 32;

    // Reject out-of-range configurations at elaboration.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT_CYCLES must be in 2..1023");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                access;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    assign access = MemWriteM | MemtoRegM;

    // Upstream freeze: while a new access is being detected and while waiting.
    assign StallM = ((state_q == ST_IDLE) & access) | (state_q == ST_REQ);

    // Next-state and request/response datapath.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d     = ST_REQ;
                    mem_req_d   = 1'b1;
                    // Store wins when both request bits are set.
                    mem_we_d    = MemWriteM;
                    mem_addr_d  = ALUOutM;
                    mem_wdata_d = WriteDataM;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end

            ST_REQ: begin
                if (mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: a timed-out load returns zero, not stale data.
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (!mem_we_q) begin
                        rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end

            ST_DONE: begin
                // Pipeline advances at the end of this cycle; never re-issue.
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout counter and error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign MemErrM = err_q;
`else
    assign MemErrM = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench: directed scenarios plus randomized transactions checked
// against a transaction-level model (expected request fields, stall length,
// last completed load value, error pulse).
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM, MemtoRegM;
    logic [31:0] ALUOutM, WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        MemErrM;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          req_cyc  = 0;
    logic [31:0] model_rd = 32'h0;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWriteM (MemWriteM),
        .MemtoRegM (MemtoRegM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .StallM    (StallM),
        .ReadDataM (ReadDataM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .MemErrM   (MemErrM)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    // Idle cycles: random stray acks must not disturb anything.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MemWriteM = 1'b0; MemtoRegM = 1'b0;
            ALUOutM = $urandom; WriteDataM = $urandom;
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            #1;
            check_eq("idle_req",   mem_req,   1'b0);
            check_eq("idle_stall", StallM,    1'b0);
            check_eq("idle_rdata", ReadDataM, model_rd);
            check_eq("idle_err",   MemErrM,   1'b0);
        end
    endtask

    // One transaction. wait_n = REQ cycles before the ack cycle; with
    // timeout set no ack is given for wait_n+1 REQ cycles.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int wait_n, input bit timeout);
        int stalls;
        bit is_load;
        bit exp_err;
        is_load = rd && !wr;
        exp_err = 1'b0;

        @(negedge clk);
        check_eq("no_dup_req", mem_req, 1'b0);
        check_eq("err_clear",  MemErrM, 1'b0);
        MemWriteM = wr; MemtoRegM = rd; ALUOutM = addr; WriteDataM = wdata;
        mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        check_eq("stall_detect", StallM, 1'b1);
        stalls = 1;

        for (int w = 0; w <= wait_n; w++) begin
            @(negedge clk);
            if (w == 0) req_cyc = cyc;
            // Inputs scrambled: the request must be held from the latched copy.
            ALUOutM = $urandom; WriteDataM = $urandom;
            if (w == wait_n && !timeout) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
            #1;
            check_eq("req_valid", mem_req,   1'b1);
            check_eq("req_we",    mem_we,    wr);
            check_eq("req_addr",  mem_addr,  addr);
            check_eq("req_wdata", mem_wdata, wdata);
            stalls += int'(StallM);
        end

        @(negedge clk);
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        if (timeout) begin
            exp_err = 1'b1;
            if (is_load) model_rd = 32'h0;
        end else if (is_load) begin
            model_rd = rdata;
        end
        check_eq("done_req",   mem_req,   1'b0);
        check_eq("done_stall", StallM,    1'b0);
        check_eq("done_rdata", ReadDataM, model_rd);
        check_eq("done_err",   MemErrM,   exp_err);
        check_eq("stall_len",  32'(stalls), 32'(wait_n + 2));
    endtask

    initial begin
        int r1;
        reset = 1'b1;
        MemWriteM = 1'b0; MemtoRegM = 1'b1; ALUOutM = 32'hFFFF_FFFF;
        WriteDataM = 32'hFFFF_FFFF; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req",   mem_req,   1'b0);
        check_eq("rst_we",    mem_we,    1'b0);
        check_eq("rst_addr",  mem_addr,  32'h0);
        check_eq("rst_wdata", mem_wdata, 32'h0);
        check_eq("rst_rdata", ReadDataM, 32'h0);
        check_eq("rst_err",   MemErrM,   1'b0);
        @(negedge clk);
        reset = 1'b0; MemtoRegM = 1'b0; mem_ack = 1'b0;
        idle_cycles(2);

        // Load with immediate ack, then store with three wait cycles.
        run_txn(1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        check_eq("load_we_in_done", mem_we, 1'b0);
        idle_cycles(1);
        run_txn(1'b1, 1'b0, 32'h200, 32'h12345678, 32'h0BAD0BAD, 3, 1'b0);
        idle_cycles(1);
        // Both request bits: treated as a store.
        run_txn(1'b1, 1'b1, 32'h204, 32'hA5A5A5A5, 32'h55AA55AA, 1, 1'b0);
        idle_cycles(1);

        // Back-to-back loads: second request rises 3 cycles after the first.
        run_txn(1'b0, 1'b1, 32'h300, 32'h0, 32'h11112222, 0, 1'b0);
        r1 = req_cyc;
        run_txn(1'b0, 1'b1, 32'h304, 32'h0, 32'h33334444, 0, 1'b0);
        check_eq("b2b_gap", 32'(req_cyc - r1), 32'd3);
        idle_cycles(1);

        // Asynchronous reset in the 2nd REQ cycle; the late ack is ignored.
        @(negedge clk);
        MemWriteM = 1'b0; MemtoRegM = 1'b1; ALUOutM = 32'h400; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("pre_rst_req", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("arst_req",   mem_req,   1'b0);
        check_eq("arst_rdata", ReadDataM, 32'h0);
        check_eq("arst_addr",  mem_addr,  32'h0);
        MemtoRegM = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        model_rd = 32'h0;
        check_eq("late_ack_req",   mem_req,   1'b0);
        check_eq("late_ack_stall", StallM,    1'b0);
        check_eq("late_ack_rdata", ReadDataM, model_rd);
        idle_cycles(1);

`ifdef MEM_TIMEOUT_EN
        // Timeouts for a load and a store; ack on the last edge still wins.
        run_txn(1'b0, 1'b1, 32'h500, 32'h0, 32'h0, TO - 1, 1'b1);
        idle_cycles(1);
        run_txn(1'b0, 1'b1, 32'h504, 32'h0, 32'h77778888, 0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h508, 32'hFEEDFACE, 32'h0, TO - 1, 1'b1);
        idle_cycles(1);
        run_txn(1'b0, 1'b1, 32'h50C, 32'h0, 32'h9999AAAA, TO - 1, 1'b0);
        idle_cycles(1);
`else
        // Without a timeout, a long wait simply completes.
        run_txn(1'b0, 1'b1, 32'h500, 32'h0, 32'h77778888, 10, 1'b0);
        idle_cycles(1);
`endif

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            int  kind;
            bit  wr, rd;
            kind = int'($urandom_range(0, 2));
            wr = (kind != 0);
            rd = (kind != 1);
            run_txn(wr, rd, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, TO - 1)), 1'b0);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, maximum REQ-state cycles without mem_ack before abort (used only with MEM_TIMEOUT_EN; legal range 2..1023).
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 MemWriteM  input  1  MEM-stage store request, from the EX/MEM pipeline register.
REQ-005 MemtoRegM  input  1  MEM-stage load request, from the EX/MEM pipeline register.
REQ-006 ALUOutM  input  32  MEM-stage byte address.
REQ-007 WriteDataM  input  32  MEM-stage store data.
REQ-008 StallM  output  1  combinational; 1 = freeze the pipeline registers upstream of MEM.
REQ-009 ReadDataM  output  32  registered load data for the MEM/WB register.
REQ-010 mem_req  output  1  registered data-memory request.
REQ-011 mem_we  output  1  registered; 1 = write, 0 = read.
REQ-012 mem_addr  output  32  registered request address.
REQ-013 mem_wdata  output  32  registered request write data.
REQ-014 mem_ack  input  1  memory completion, sampled at a rising edge.
REQ-015 mem_rdata  input  32  read data, valid in any cycle where mem_ack=1.
REQ-016 MemErrM  output  1  registered one-cycle timeout error pulse.

Function
REQ-017 FSM states: IDLE, REQ and DONE, 2-bit encoding.
REQ-018 access = MemWriteM | MemtoRegM.
REQ-019 If MemWriteM=1 and MemtoRegM=1 together, the access is a write, and ReadDataM is not updated.
REQ-020 StallM = (state==IDLE & access) | (state==REQ).
REQ-021 StallM = 0 in DONE, so the pipeline advances at the end of DONE.
REQ-022 IDLE & access at an edge: go to REQ.
- Same edge: mem_req<=1, mem_we<=MemWriteM, mem_addr<=ALUOutM, mem_wdata<=WriteDataM.
REQ-023 In REQ, mem_req, mem_we, mem_addr and mem_wdata stay stable until the edge where mem_ack=1.
REQ-024 REQ & mem_ack at an edge: go to DONE and clear mem_req.
- Same edge, if the access is a load (mem_we=0): ReadDataM<=mem_rdata.
REQ-025 DONE always goes to IDLE after one cycle; DONE issues no request even when access=1.
REQ-026 mem_ack in IDLE or DONE is ignored and changes no state.
REQ-027 Latency: ack in the first REQ cycle gives 3 cycles from IDLE detect to IDLE (2 stall cycles); each extra wait cycle adds one.
REQ-028 ReadDataM holds its value until the next completed load.
REQ-029 Back-to-back accesses: the next access is detected in the IDLE cycle right after DONE.

Reset
REQ-030 reset=1 forces the following at once, whatever the clock:
- state IDLE, mem_req 0, mem_we 0
- mem_addr 0, mem_wdata 0, ReadDataM 0, MemErrM 0, timeout counter 0.
REQ-031 Reset during REQ abandons the transaction; a later mem_ack from that transaction is ignored (REQ-026).
REQ-032 After reset falls, an access present in IDLE starts normally at the next rising edge.

Configuration
REQ-033 Macro MEM_TIMEOUT_EN defined:
- A counter of width $clog2(TIMEOUT_CYCLES) clears on entry to REQ and increments each REQ cycle without ack.
- At the edge where the count equals TIMEOUT_CYCLES-1 and mem_ack=0: clear mem_req, go to DONE, ReadDataM<=0 if load, MemErrM<=1 for exactly the DONE cycle.
- mem_ack=1 on that same edge takes priority: normal completion, no error.
REQ-034 Macro MEM_TIMEOUT_EN undefined: REQ waits indefinitely, no counter is built, MemErrM is tied to 0.

Verification
REQ-035 Load: ALUOutM=0x100, MemtoRegM=1, mem_ack=1 in the first REQ cycle, mem_rdata=0xDEADBEEF -> StallM high for 2 cycles; ReadDataM=0xDEADBEEF in DONE; mem_we=0.
REQ-036 Store: ALUOutM=0x200, WriteDataM=0x12345678, ack after 3 wait cycles -> mem_addr/mem_wdata stable for 4 REQ cycles; StallM high for 5 cycles; ReadDataM unchanged.
REQ-037 MemWriteM=1 and MemtoRegM=1 at once -> mem_we=1; ReadDataM unchanged after ack.
REQ-038 reset pulsed in the 2nd REQ cycle, then mem_ack=1 -> mem_req 0 immediately; state IDLE; ack ignored; ReadDataM=0.
REQ-039 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req falls after 4 REQ cycles; MemErrM=1 for one cycle; ReadDataM=0; StallM releases.
REQ-040 Two loads back-to-back with immediate acks -> second mem_req rises 3 cycles after the first; DONE issues no duplicate request.
